// File: rtl/apb_event_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_event_irq_ctrl_if
//
// APB slave bus bundle for the event/interrupt controller.
//   PADDR   : byte address (APB_ADDR_WIDTH bits)
//   PWDATA  : write data
//   PWRITE  : 1 = write, 0 = read
//   PSEL    : slave select
//   PENABLE : access phase strobe
//   PRDATA  : read data (0 outside a read access)
//   PREADY  : always 1, no wait states
//   PSLVERR : access error flag, valid in the access phase
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface apb_event_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_event_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_event_irq_ctrl
//
// APB-programmable interrupt/event controller. NUM_IRQ sources are latched
// into a PENDING vector (level or edge detect), arbitrated lowest-index-first
// and presented to the core through a registered request/ID/ack handshake.
// After an ack the controller stays in service until software writes EOI.
//
// Ports:
//   HCLK       clock
//   HRESETn    synchronous active-low reset
//   apb        APB slave bundle (apb_event_irq_ctrl_if.slave)
//   signal_i   raw sources, synchronous to HCLK
//   irq_req_o  interrupt request to the core (registered)
//   irq_id_o   ID of the requested interrupt (registered)
//   irq_o      one-hot of irq_id_o while irq_req_o=1, else 0 (registered)
//   irq_ack_i  core accepts the current request
//
// Register map (byte offsets, decoded on PADDR[7:2]):
//   0x00 ENABLE RW | 0x04 PENDING RW | 0x08 SET WO | 0x0C CLEAR WO
//   0x10 MODE RW   | 0x14 STATUS RO  | 0x18 EOI WO
//
// Build option: define APB_EVENT_IRQ_EDGE_EN to include the MODE register and
// per-source edge detection. Without it every source is level-triggered,
// MODE reads 0 and writes to it are silently discarded.
// ---------------------------------------------------------------------------
module apb_event_irq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_IRQ        = 32,
  parameter int ID_WIDTH       = $clog2(NUM_IRQ)
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  apb_event_irq_ctrl_if.slave apb,
  input  logic [NUM_IRQ-1:0]  signal_i,
  output logic                irq_req_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  output logic [NUM_IRQ-1:0]  irq_o,
  input  logic                irq_ack_i
);

  localparam logic [5:0] A_ENABLE  = 6'd0;
  localparam logic [5:0] A_PENDING = 6'd1;
  localparam logic [5:0] A_SET     = 6'd2;
  localparam logic [5:0] A_CLEAR   = 6'd3;
  localparam logic [5:0] A_MODE    = 6'd4;
  localparam logic [5:0] A_STATUS  = 6'd5;
  localparam logic [5:0] A_EOI     = 6'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   enable_q, enable_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic                 irq_req_q, irq_req_d;
  logic [ID_WIDTH-1:0]  irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0]   irq_oh_q, irq_oh_d;

  logic [5:0]           reg_idx;
  logic                 access, wr, rd;
  logic [NUM_IRQ-1:0]   wdata;
  logic [NUM_IRQ-1:0]   hit, set_w, clr_w, ack_clr;
  logic                 ack_take, eoi, req_cancel;
  logic [ID_WIDTH-1:0]  sel_id;
  logic [NUM_IRQ-1:0]   sel_oh;

  assign reg_idx = apb.PADDR[7:2];
  assign access  = apb.PSEL & apb.PENABLE;
  assign wr      = access & apb.PWRITE;
  assign rd      = access & ~apb.PWRITE;
  assign wdata   = apb.PWDATA[NUM_IRQ-1:0];

  // Address bits outside the register window and unstored data bits.
  logic unused_addr;
  assign unused_addr = ^{apb.PADDR[APB_ADDR_WIDTH-1:8], apb.PADDR[1:0]};
  if (NUM_IRQ < 32) begin : g_unused_pwdata
    logic unused_pwdata;
    assign unused_pwdata = ^apb.PWDATA[31:NUM_IRQ];
  end

`ifdef APB_EVENT_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] mode_q, mode_d, prev_q;
  assign mode_d = (wr && reg_idx == A_MODE) ? wdata : mode_q;
  // Edge-mode sources only hit on a 0->1 transition against last cycle.
  assign hit    = enable_q & signal_i & ~(mode_q & prev_q);
`else
  assign hit    = enable_q & signal_i;
`endif

  assign ack_take = (state_q == S_REQ) && irq_ack_i;
  assign eoi      = wr && (reg_idx == A_EOI) && (state_q == S_SERVICE);
  assign set_w    = (wr && reg_idx == A_SET)   ? wdata : '0;
  assign clr_w    = (wr && reg_idx == A_CLEAR) ? wdata : '0;
  assign ack_clr  = ack_take ? irq_oh_q : '0;
  assign enable_d = (wr && reg_idx == A_ENABLE) ? wdata : enable_q;

  // A PENDING write replaces the vector outright; otherwise clears win over sets.
  always_comb begin
    if (wr && reg_idx == A_PENDING) begin
      pending_d = wdata;
    end else begin
      pending_d = (pending_q | hit | set_w) & ~clr_w & ~ack_clr;
    end
  end

  // Lowest pending index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_id = ID_WIDTH'(i);
    end
    sel_oh = '0;
    sel_oh[sel_id] = 1'b1;
  end

  // Software dropped the requested bit before the core took it.
  assign req_cancel = (state_q == S_REQ) && !irq_ack_i && !pending_d[irq_id_q];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      irq_oh_q  <= '0;
`ifdef APB_EVENT_IRQ_EDGE_EN
      mode_q    <= '0;
      prev_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
      irq_oh_q  <= irq_oh_d;
`ifdef APB_EVENT_IRQ_EDGE_EN
      mode_q    <= mode_d;
      prev_q    <= signal_i;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|pending_q) state_d = S_REQ;
      S_REQ: begin
        if (ack_take)        state_d = S_SERVICE;
        else if (req_cancel) state_d = S_IDLE;
      end
      S_SERVICE: if (eoi) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ID/one-hot are frozen while in REQ; a higher-priority arrival waits.
  always_comb begin
    irq_req_d = irq_req_q;
    irq_id_d  = irq_id_q;
    irq_oh_d  = irq_oh_q;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          irq_req_d = 1'b1;
          irq_id_d  = sel_id;
          irq_oh_d  = sel_oh;
        end
      end
      S_REQ: begin
        if (ack_take || req_cancel) begin
          irq_req_d = 1'b0;
          irq_oh_d  = '0;
        end
      end
      default: begin
        irq_req_d = 1'b0;
        irq_oh_d  = '0;
      end
    endcase
  end

  assign irq_req_o = irq_req_q;
  assign irq_id_o  = irq_id_q;
  assign irq_o     = irq_oh_q;

  // Read mux and error decode.
  always_comb begin
    logic [31:0] rdata;
    logic        err;
    rdata = '0;
    err   = 1'b0;
    if (access) begin
      case (reg_idx)
        A_ENABLE:  if (rd) rdata = zext(enable_q);
        A_PENDING: if (rd) rdata = zext(pending_q);
        A_SET, A_CLEAR, A_EOI: err = rd;
        A_MODE: begin
`ifdef APB_EVENT_IRQ_EDGE_EN
          if (rd) rdata = zext(mode_q);
`endif
        end
        A_STATUS: begin
          if (rd) begin
            if (state_q == S_SERVICE) begin
              rdata[31]           = 1'b1;
              rdata[ID_WIDTH-1:0] = irq_id_q;
            end
          end else begin
            err = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
    end
    apb.PRDATA  = rdata;
    apb.PSLVERR = err;
  end

  assign apb.PREADY = 1'b1;

endmodule

// File: doc/apb_event_irq_ctrl.md
Name: apb_event_irq_ctrl

Overview:
Parametrised APB interrupt/event controller. Successor to the fixed 32-line service unit.
- NUM_IRQ sources, each configurable as level- or edge-triggered.
- Fixed lowest-index-first priority.
- Registered request/ID/acknowledge handshake to the core, with explicit end-of-interrupt (EOI) so only one interrupt is in service at a time.
- Sits on the peripheral APB bus between event sources and the core interrupt input.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave).
- NUM_IRQ, 32, number of interrupt sources; legal 2..32.
- ID_WIDTH, $clog2(NUM_IRQ), width of the interrupt ID. Derived; do not override.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  access error.
- signal_i  in  NUM_IRQ  raw event/interrupt sources, synchronous to HCLK.
- irq_req_o  out  1  interrupt request to core.
- irq_id_o  out  ID_WIDTH  ID of the requested interrupt.
- irq_o  out  NUM_IRQ  one-hot copy of irq_id_o; valid while irq_req_o=1, else 0.
- irq_ack_i  in  1  core accepts the current request.

Behaviour:
- Clocking and reset: single clock HCLK. Reset HRESETn is synchronous, active-low. While HRESETn=0 at a rising edge, the following load 0: all registers, FSM (→IDLE), edge history, irq_req_o, irq_id_o, irq_o. Reset mid-handshake abandons the request; no ack is expected afterwards.
- Register map (PADDR[7:2]); an access is PSEL&PENABLE:
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: RW; a write replaces the whole vector.
  - 0x08 SET: WO; write-1-to-set.
  - 0x0C CLEAR: WO; write-1-to-clear.
  - 0x10 MODE: RW; 1 = edge, 0 = level.
  - 0x14 STATUS: RO; bit31 = in_service, bits[ID_WIDTH-1:0] = active ID.
  - 0x18 EOI: WO; any write ends service.
- Register width and reads: only bits [NUM_IRQ-1:0] are stored; upper bits read 0. WO registers read 0.
- PSLVERR=1 in the access cycle for:
  - an unmapped address;
  - a write to STATUS;
  - a read of SET, CLEAR or EOI.
  PSLVERR=0 otherwise. PRDATA is combinational, 0 outside a read access.
- Source detect per bit i:
  - level: hit = ENABLE[i] & signal_i[i].
  - edge: hit = ENABLE[i] & signal_i[i] & ~prev[i], where prev is signal_i registered every cycle.
- Pending next-state:
  - If this cycle has a PENDING write: next = PWDATA. It overrides all of the below.
  - Otherwise: next = (PENDING | hit | SET_wdata) & ~CLEAR_wdata & ~ack_clr.
  - ack_clr is the one-hot of irq_id_o when irq_req_o & irq_ack_i.
  - CLEAR beats hit/SET on the same bit in the same cycle.
- Selection: sel_id = lowest index i with PENDING[i]=1.
- FSM, registered outputs:
  - IDLE: if PENDING≠0 → REQ; load irq_id_o=sel_id, irq_o=onehot(sel_id), irq_req_o=1.
  - REQ: irq_id_o/irq_o held stable (no re-arbitration even if a higher-priority bit pends). On irq_ack_i → SERVICE; irq_req_o=0, irq_o=0, pending bit cleared, STATUS.in_service=1, active ID retained.
  - REQ, selected bit cleared by software before ack (CLEAR or PENDING write): → IDLE, irq_req_o=0 next edge, no ack needed.
  - SERVICE: no new requests. EOI write → IDLE; in_service=0 next edge.
  - irq_ack_i outside REQ is ignored. EOI outside SERVICE is ignored.
- Latency:
  - signal_i rises in cycle k (enabled, FSM IDLE) → PENDING set after edge k, irq_req_o=1 after edge k+1.
  - EOI in cycle m with other bits pending → irq_req_o=1 after edge m+1.
- Level source still high after ack: re-pends on the next cycle and is requested again after EOI.
- ENABLE cleared: stops new hits only; already-pending bits remain.

Optional Feature:
- Macro: APB_EVENT_IRQ_EDGE_EN.
- Defined: MODE register, prev history flops and edge detection present as above.
- Undefined: no prev flops; every source is level-triggered; MODE reads 0, and writes to MODE are accepted and discarded (PSLVERR=0).

Test Plan:
- Level source: ENABLE=0x5, signal_i[2]=1 at cycle 10 → PENDING=0x4 after edge 10; irq_req_o=1, irq_id_o=2, irq_o=0x4 after edge 11; ack → PENDING bit2 re-sets while signal high; after EOI write, request for ID 2 reissued 2 edges later.
- Priority and stable ID: SET=0x0000_0030 → request ID 4; while in REQ, SET=0x1 → irq_id_o stays 4; ack, EOI → next request ID 0, then ID 5.
- Edge mode (macro on): MODE=0x8, ENABLE=0x8, signal_i[3] held high 20 cycles → exactly one pend/request; without the macro, same stimulus → re-pends after every ack.
- Software cancel: request ID 7 pending in REQ, write CLEAR=0x80 → irq_req_o=0 next edge, FSM IDLE, no ack needed; STATUS reads 0.
- APB errors: read 0x08 → PSLVERR=1, PRDATA=0; write 0x14 → PSLVERR=1, STATUS unchanged; read 0x3C → PSLVERR=1.
- Reset mid-service: NUM_IRQ=8, in SERVICE with PENDING=0x11, hold HRESETn=0 one edge → all registers 0, irq_req_o=0, STATUS=0; afterwards, idle with no request until a new hit.
